// File: rtl/wtm_seq_mult_pkg.sv
// Shared widths and FSM encoding for the 10x10 sequential multiplier
// built on a single 5x5 Wallace tree.
package wtm_seq_mult_pkg;

    localparam int DIG_W  = 5;
    localparam int OP_W   = 2 * DIG_W;
    localparam int PROD_W = 2 * OP_W;
    localparam int PASS_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wtm_seq_mult_wtm.sv
// Combinational 5x5 unsigned Wallace tree multiplier: five partial-product
// rows reduced by three carry-save stages, then one carry-propagate add.
module wtm_seq_mult_wtm
    import wtm_seq_mult_pkg::*;
(
    input  logic [DIG_W-1:0]   a,
    input  logic [DIG_W-1:0]   b,
    output logic [2*DIG_W-1:0] out,
    output logic               cout
);

    localparam int W = 2 * DIG_W + 1;

    logic [W-1:0] pp [DIG_W];
    logic [W-1:0] s1, c1, s2, c2, s3, c3, sum;

    generate
        for (genvar gi = 0; gi < DIG_W; gi++) begin : g_pp
            assign pp[gi] = W'({DIG_W{b[gi]}} & a) << gi;
        end
    endgenerate

    // Each stage folds three rows into a sum row and a shifted carry row.
    assign s1 = pp[0] ^ pp[1] ^ pp[2];
    assign c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;

    assign s2 = s1 ^ c1 ^ pp[3];
    assign c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;

    assign s3 = s2 ^ c2 ^ pp[4];
    assign c3 = ((s2 & c2) | (s2 & pp[4]) | (c2 & pp[4])) << 1;

    assign sum  = s3 + c3;
    assign out  = sum[2*DIG_W-1:0];
    assign cout = sum[W-1];

endmodule

// File: rtl/wtm_seq_mult.sv
// 10x10 unsigned multiplier sequencing four digit products through one WTM.
// Optional WTM_ZERO_SKIP_EN: a zero operand bypasses the passes (1-cycle op).
module wtm_seq_mult
    import wtm_seq_mult_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_t              state_reg, state_next;
    logic [OP_W-1:0]     a_reg, b_reg;
    logic [PROD_W-1:0]   acc_reg, acc_next, term;
    logic [PROD_W-1:0]   product_reg;
    logic [PASS_W-1:0]   pass_reg;
    logic [DIG_W-1:0]    a_dig, b_dig;
    logic [2*DIG_W-1:0]  wtm_out;
    logic                wtm_cout;
    logic                zero_op;

`ifdef WTM_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // pass[1] picks the a digit, pass[0] the b digit: (lo,lo),(lo,hi),(hi,lo),(hi,hi).
    assign a_dig = pass_reg[1] ? a_reg[OP_W-1:DIG_W] : a_reg[DIG_W-1:0];
    assign b_dig = pass_reg[0] ? b_reg[OP_W-1:DIG_W] : b_reg[DIG_W-1:0];

    wtm_seq_mult_wtm u_wtm (
        .a    (a_dig),
        .b    (b_dig),
        .out  (wtm_out),
        .cout (wtm_cout)
    );

    // cout is always 0 for 5-bit digits; folding it in keeps the sum exact anyway.
    always_comb begin
        term     = PROD_W'({wtm_cout, wtm_out})
                   << (DIG_W * (32'(pass_reg[1]) + 32'(pass_reg[0])));
        acc_next = acc_reg + term;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = zero_op ? DONE : MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (&pass_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            pass_reg    <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        acc_reg  <= '0;
                        pass_reg <= '0;
                        if (zero_op) begin
                            product_reg <= '0;
                        end
                    end
                end
                MUL: begin
                    acc_reg  <= acc_next;
                    pass_reg <= pass_reg + 2'd1;
                    if (&pass_reg) begin
                        product_reg <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = product_reg;

endmodule

// File: tb/tb_wtm_seq_mult.sv
// Scoreboard bench for wtm_seq_mult: driver pushes a*b and due cycle per op,
// a negedge monitor pops and checks on every done pulse.
module tb_wtm_seq_mult;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  a, b;
    logic        ready, busy, done;
    logic [19:0] product;

    wtm_seq_mult dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [19:0] prod;
        int          due;
        int          opa;
        int          opb;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [19:0] held = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("product_%0dx%0d", e.opa, e.opb), 32'(product), 32'(e.prod));
                    check($sformatf("latency_%0dx%0d", e.opa, e.opb), 32'(cyc), 32'(e.due));
                    held = e.prod;
                    $display("op a=%0d b=%0d product=%0d expected=%0d cycle=%0d",
                             e.opa, e.opb, product, e.prod, cyc);
                end
            end else if (busy) begin
                check("product_hold", 32'(product), 32'(held));
            end
        end
    end

    task automatic do_op(input logic [9:0] x, input logic [9:0] y, input bit track);
        int   n;
        int   lat;
        exp_t e;
        n = 0;
        @(negedge clock);
        while (!ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = 10'($urandom);
        b     = 10'($urandom);
        lat   = 4;
`ifdef WTM_ZERO_SKIP_EN
        if (x == 0 || y == 0) lat = 1;
`endif
        if (track) begin
            e.prod = 20'(int'(x) * int'(y));
            e.due  = cyc + lat;
            e.opa  = int'(x);
            e.opb  = int'(y);
            sb.push_back(e);
        end
    endtask

    initial begin
        int          n;
        logic [9:0]  x, y;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);

        do_op(10'd25, 10'd16, 1'b1);
        do_op(10'd1023, 10'd1023, 1'b1);
        do_op(10'd700, 10'd300, 1'b1);
        do_op(10'd31, 10'd1, 1'b1);

        // start re-asserted during MUL must be ignored
        do_op(10'd5, 10'd7, 1'b1);
        @(negedge clock);
        start = 1'b1;
        a     = 10'd9;
        b     = 10'd9;
        @(negedge clock);
        check("busy_in_mul", 32'(busy), 32'd1);
        @(negedge clock);
        start = 1'b0;

        // reset after pass 1 aborts the op with no done
        do_op(10'd100, 10'd200, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        held = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        do_op(10'd3, 10'd4, 1'b1);

        do_op(10'd0, 10'd20, 1'b1);
        do_op(10'd513, 10'd0, 1'b1);

        for (int i = 0; i < 25; i++) begin
            x = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
            y = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
            do_op(x, y, 1'b1);
        end

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
